// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
// One conversion takes BIN_W shift cycles plus one output-load cycle.
// The block also produces a leading-zero significance mask and an overflow flag.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 16,
    parameter int unsigned DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     sig_mask,
    output logic                  ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [BIN_W-1:0]   shift_q, shift_d;
    logic [BCD_W-1:0]   bcd_acc_q, bcd_acc_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic [DIGITS-1:0]  sig_mask_q, sig_mask_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   adj;
    logic [DIGITS-1:0]  mask;
    logic               load;

    // Add-3 correction: every digit of 5 or more is bumped before the shift.
    always_comb begin
        adj = bcd_acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Significance mask: a digit is significant if it or any higher digit is non-zero.
    always_comb begin
        logic seen;
        seen = 1'b0;
        mask = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            seen    = seen | (|bcd_acc_q[4*i +: 4]);
            mask[i] = seen;
        end
        mask[0] = 1'b1;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bcd_acc_d  = bcd_acc_q;
        ovf_acc_d  = ovf_acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        bcd_out_d  = bcd_out_q;
        sig_mask_d = sig_mask_q;
        ovf_d      = ovf_q;
        load       = 1'b0;

        unique case (state_q)
            StIdle: begin
                load = start;
            end
            StShift: begin
                bcd_acc_d = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
                shift_d   = shift_q << 1;
                ovf_acc_d = ovf_acc_q | adj[BCD_W-1];
                cnt_d     = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StDone;
                    busy_d  = 1'b0;
                end
            end
            StDone: begin
                bcd_out_d  = bcd_acc_q;
                sig_mask_d = mask;
                ovf_d      = ovf_acc_q;
                done_d     = 1'b1;
                state_d    = StIdle;
                // Back-to-back: a new request is taken on the same edge as the result.
                load       = start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (load) begin
            shift_d   = bin_in;
            bcd_acc_d = '0;
            ovf_acc_d = 1'b0;
            cnt_d     = CNT_W'(BIN_W);
            busy_d    = 1'b1;
            state_d   = StShift;
        end
    end

    // State and datapath registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bcd_acc_q  <= '0;
            ovf_acc_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_out_q  <= '0;
            sig_mask_q <= DIGITS'(1);
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bcd_acc_q  <= bcd_acc_d;
            ovf_acc_q  <= ovf_acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            bcd_out_q  <= bcd_out_d;
            sig_mask_q <= sig_mask_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_out_q;
    assign sig_mask = sig_mask_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: default 16-bit/5-digit instance and a
// truncating 8-bit/2-digit instance, checked against a division-based model.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;

    logic        start_a;
    logic [15:0] bin_a;
    logic        busy_a, done_a, ovf_a;
    logic [19:0] bcd_a;
    logic [4:0]  mask_a;

    logic        start_b;
    logic [7:0]  bin_b;
    logic        busy_b, done_b, ovf_b;
    logic [7:0]  bcd_b;
    logic [1:0]  mask_b;

    int checks;
    int failures;

    bit          sel;
    logic        busy_s, done_s, ovf_s;
    logic [19:0] bcd_s;
    logic [4:0]  mask_s;

    bin2bcd_seq dut_a (
        .clk      (clk),
        .rst      (rst),
        .start    (start_a),
        .bin_in   (bin_a),
        .busy     (busy_a),
        .done     (done_a),
        .bcd_out  (bcd_a),
        .sig_mask (mask_a),
        .ovf      (ovf_a)
    );

    bin2bcd_seq #(
        .BIN_W  (8),
        .DIGITS (2)
    ) dut_b (
        .clk      (clk),
        .rst      (rst),
        .start    (start_b),
        .bin_in   (bin_b),
        .busy     (busy_b),
        .done     (done_b),
        .bcd_out  (bcd_b),
        .sig_mask (mask_b),
        .ovf      (ovf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        busy_s = sel ? busy_b : busy_a;
        done_s = sel ? done_b : done_a;
        ovf_s  = sel ? ovf_b  : ovf_a;
        bcd_s  = sel ? {12'h000, bcd_b} : bcd_a;
        mask_s = sel ? {3'b000, mask_b} : mask_a;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned pow10(input int digits);
        int unsigned p;
        p = 1;
        for (int i = 0; i < digits; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic [31:0] ref_bcd(input int unsigned v, input int digits);
        logic [31:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            r = r | (32'((v / p) % 10) << (4 * i));
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_mask(input int unsigned v, input int digits);
        logic [31:0] m;
        int unsigned t;
        int unsigned p;
        t = v % pow10(digits);
        m = 32'd1;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            if ((t / p) != 0) m = m | (32'd1 << i);
            p = p * 10;
        end
        return m;
    endfunction

    function automatic logic [31:0] ref_ovf(input int unsigned v, input int digits);
        return (v >= pow10(digits)) ? 32'd1 : 32'd0;
    endfunction

    // One conversion on the selected instance: latency, busy, result, done width.
    task automatic convert(input bit use_b, input int unsigned v);
        int n;
        int digits;
        int lat_exp;
        logic busy_mid;
        sel     = use_b;
        digits  = use_b ? 2 : 5;
        lat_exp = use_b ? 9 : 17;
        @(negedge clk);
        if (use_b) begin
            start_b = 1'b1;
            bin_b   = 8'(v);
        end else begin
            start_a = 1'b1;
            bin_a   = 16'(v);
        end
        @(posedge clk);
        #1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        bin_a    = 16'($urandom);
        bin_b    = 8'($urandom);
        busy_mid = busy_s;
        n = 0;
        while (!done_s && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("busy_after_start", 32'(busy_mid), 32'd1);
        check_eq("latency", 32'(n), 32'(lat_exp));
        check_eq("bcd_out", 32'(bcd_s), ref_bcd(v, digits));
        check_eq("sig_mask", 32'(mask_s), ref_mask(v, digits));
        check_eq("ovf", 32'(ovf_s), ref_ovf(v, digits));
        @(posedge clk);
        #1;
        check_eq("done_width", 32'(done_s), 32'd0);
    endtask

    initial begin
        int ndone;
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        bin_a    = '0;
        bin_b    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy_a), 32'd0);
        check_eq("rst_done", 32'(done_a), 32'd0);
        check_eq("rst_bcd", 32'(bcd_a), 32'd0);
        check_eq("rst_mask", 32'(mask_a), 32'd1);
        check_eq("rst_ovf", 32'(ovf_a), 32'd0);
        check_eq("rst_mask_b", 32'(mask_b), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Directed corner values.
        convert(1'b0, 0);
        convert(1'b0, 65535);
        convert(1'b0, 1234);
        convert(1'b0, 10);
        convert(1'b0, 9);
        convert(1'b1, 255);
        convert(1'b1, 99);
        convert(1'b1, 100);
        convert(1'b1, 0);

        // Back-to-back with start held high; bin_in changes mid-conversion.
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 16'd255;
        @(posedge clk);
        #1;
        bin_a = 16'd9999;
        ndone = 0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                ndone++;
                if (ndone == 1) begin
                    check_eq("b2b_lat1", 32'(n), 32'd17);
                    check_eq("b2b_bcd1", 32'(bcd_a), ref_bcd(255, 5));
                end else if (ndone == 2) begin
                    check_eq("b2b_lat2", 32'(n), 32'd34);
                    check_eq("b2b_bcd2", 32'(bcd_a), ref_bcd(9999, 5));
                end
            end
            if (n == 18) check_eq("b2b_busy2", 32'(busy_a), 32'd1);
            if (n == 33) start_a = 1'b0;
        end
        check_eq("b2b_count", 32'(ndone), 32'd2);
        check_eq("b2b_idle", 32'(busy_a), 32'd0);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start_a = 1'b1;
        bin_a   = 16'd4096;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy_a), 32'd0);
        check_eq("abort_done", 32'(done_a), 32'd0);
        check_eq("abort_bcd", 32'(bcd_a), 32'd0);
        check_eq("abort_mask", 32'(mask_a), 32'd1);
        check_eq("abort_ovf", 32'(ovf_a), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done_a) ndone++;
        end
        check_eq("abort_no_done", 32'(ndone), 32'd0);
        convert(1'b0, 7);

        // Randomized sweep against the division model.
        for (int k = 0; k < 2000; k++) begin
            convert(1'b0, $urandom_range(0, 65535));
        end
        for (int k = 0; k < 100; k++) begin
            convert(1'b1, $urandom_range(0, 255));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
